// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor controller: FSM, ALU decode, condition check, NZCV flags
module multicycle_ctrl #(
    parameter int MEM_WAIT = 1,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:12]        Instr,
    input  logic [3:0]          ALUFlags,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                IRWrite,
    output logic                AdrSrc,
    output logic [1:0]          RegSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic [3:0]          Flags,
    output logic                Undef,
    output logic [3:0]          State
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] UNDEF  = 4'd10;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_ORR = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_EOR = ALUCTL_W'(4);
    localparam bit                  EOR_OK  = (ALUCTL_W >= 3);

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       l_bit;
    logic       rd_pc;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign i_bit     = Instr[25];
    assign cmd       = Instr[24:21];
    assign s_bit     = Instr[20];
    assign l_bit     = Instr[20];
    assign rd_pc     = (Instr[15:12] == 4'hF);
    assign unused_rn = ^Instr[19:16];

    logic ready;
    assign ready = (MEM_WAIT == 0) ? 1'b1 : MemReady;

    // ARM condition check against the architectural flags
    logic cond_ok;
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = flags_q[2];
            4'h1: cond_ok = ~flags_q[2];
            4'h2: cond_ok = flags_q[1];
            4'h3: cond_ok = ~flags_q[1];
            4'h4: cond_ok = flags_q[3];
            4'h5: cond_ok = ~flags_q[3];
            4'h6: cond_ok = flags_q[0];
            4'h7: cond_ok = ~flags_q[0];
            4'h8: cond_ok = flags_q[1] & ~flags_q[2];
            4'h9: cond_ok = ~flags_q[1] | flags_q[2];
            4'hA: cond_ok = (flags_q[3] == flags_q[0]);
            4'hB: cond_ok = (flags_q[3] != flags_q[0]);
            4'hC: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Data-processing command decode: ALU op, legality, CMP and carry/overflow ownership
    logic                cmd_valid;
    logic                is_cmp;
    logic                cv_upd;
    logic [ALUCTL_W-1:0] alu_op;
    always_comb begin
        cmd_valid = 1'b1;
        is_cmp    = 1'b0;
        cv_upd    = 1'b0;
        alu_op    = ALU_ADD;
        case (cmd)
            4'b0100: begin alu_op = ALU_ADD; cv_upd = 1'b1; end
            4'b0010: begin alu_op = ALU_SUB; cv_upd = 1'b1; end
            4'b0000: alu_op = ALU_AND;
            4'b1100: alu_op = ALU_ORR;
            4'b1010: begin alu_op = ALU_SUB; cv_upd = 1'b1; is_cmp = 1'b1; end
            4'b0001: begin
                if (EOR_OK) alu_op = ALU_EOR;
                else        cmd_valid = 1'b0;
            end
            default: cmd_valid = 1'b0;
        endcase
    end

    // Illegal encodings halt regardless of the condition field
    logic illegal;
    assign illegal = (cond == 4'hF) || (op == 2'b11) || ((op == 2'b00) && !cmd_valid);

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (ready) state_d = DECODE;
            DECODE: begin
                if (illegal)       state_d = UNDEF;
                else if (!cond_ok) state_d = FETCH;
                else begin
                    case (op)
                        2'b00:   state_d = i_bit ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = UNDEF;
                    endcase
                end
            end
            MEMADR: state_d = l_bit ? MEMRD : MEMWR;
            MEMRD:  if (ready) state_d = MEMWB;
            MEMWR:  if (ready) state_d = FETCH;
            EXECR, EXECI: state_d = is_cmp ? FETCH : ALUWB;
            MEMWB, ALUWB, BRANCH: state_d = FETCH;
            UNDEF:  state_d = UNDEF;
            default: state_d = FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Flags load as the execute state is left; C/V only for arithmetic ops
    always_comb begin
        flags_d = flags_q;
        if (((state_q == EXECR) || (state_q == EXECI)) && s_bit) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (cv_upd) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Architectural flags register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    // Ready-qualified strobes are suppressed while reset is held
    logic fetch_go;
    assign fetch_go = ready & ~reset;

    // Per-state datapath controls
    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = op;
        RegSrc     = {(op == 2'b01) & ~l_bit, (op == 2'b10)};
        case (state_q)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = fetch_go;
                PCWrite   = fetch_go;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = rd_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR:  ALUControl = alu_op;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = rd_pc;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign Flags = flags_q;
    assign Undef = (state_q == UNDEF);
    assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a path-level reference model
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:12] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  Flags;
    logic        Undef;
    logic [3:0]  State;

    multicycle_ctrl #(.MEM_WAIT(1), .ALUCTL_W(3)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Flags(Flags),
        .Undef(Undef), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [3:0] m_flags;
    logic [3:0] cmds [6] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'h1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int alu_code(input logic [3:0] c);
        case (c)
            4'h4: return 0;
            4'h2: return 1;
            4'h0: return 2;
            4'hC: return 3;
            4'hA: return 1;
            4'h1: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Expected outputs for one cycle spent in state st with the given instruction and ready level
    task automatic check_outputs(input int st, input logic [31:12] ins, input logic rdy);
        logic [3:0]  strb;   // {PCWrite, MemWrite, RegWrite, IRWrite}
        logic [10:0] sel;    // {AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc}
        logic        adr;
        logic [1:0]  asa, asb, rs, rsrc;
        int          alu;
        bit          rd15;
        string       t;
        rd15 = (ins[15:12] == 4'hF);
        strb = 4'b0000; adr = 1'b0; asa = 2'd0; asb = 2'd0; rs = 2'd0; alu = 0;
        case (st)
            0: begin asa = 2'd1; asb = 2'd2; rs = 2'd2; strb = {rdy, 1'b0, 1'b0, rdy}; end
            1: begin asa = 2'd1; asb = 2'd2; rs = 2'd2; end
            2: asb = 2'd1;
            3: adr = 1'b1;
            4: begin rs = 2'd1; strb = {rd15, 1'b0, 1'b1, 1'b0}; end
            5: begin adr = 1'b1; strb = 4'b0100; end
            6: alu = alu_code(ins[24:21]);
            7: begin asb = 2'd1; alu = alu_code(ins[24:21]); end
            8: strb = {rd15, 1'b0, 1'b1, 1'b0};
            9: begin asa = 2'd2; asb = 2'd1; rs = 2'd2; strb = 4'b1000; end
            default: ;
        endcase
        rsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
        sel  = {adr, rsrc, asa, asb, rs, ins[27:26]};
        t = $sformatf("i%05h_s%0d", ins, st);
        chk({t, "_state"}, State, st);
        chk({t, "_strobes"}, {PCWrite, MemWrite, RegWrite, IRWrite}, strb);
        chk({t, "_undef"}, Undef, st == 10);
        chk({t, "_aluctl"}, ALUControl, alu);
        chk({t, "_flags"}, Flags, m_flags);
        chk({t, "_selects"}, {AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc}, sel);
    endtask

    // Runs one instruction from FETCH to its last state; the path is built from the instruction class
    task automatic run_instr(input logic [31:12] ins, input bit rnd_rdy, input int stall,
                             input bit fix_af, input logic [3:0] af);
        int         path[$];
        int         idx, st, held, guard, stall_left;
        logic [3:0] cmd;
        logic [1:0] op;
        logic       rdy;
        bit         illegal;
        Instr = ins;
        op  = ins[27:26];
        cmd = ins[24:21];
        illegal = (ins[31:28] == 4'hF) || (op == 2'b11) || (op == 2'b00 && alu_code(cmd) < 0);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        if (illegal) path.push_back(10);
        else if (cond_holds(ins[31:28], m_flags)) begin
            case (op)
                2'b00: begin
                    path.push_back(ins[25] ? 7 : 6);
                    if (cmd != 4'hA) path.push_back(8);
                end
                2'b01: begin
                    path.push_back(2);
                    path.push_back(ins[20] ? 3 : 5);
                    if (ins[20]) path.push_back(4);
                end
                default: path.push_back(9);
            endcase
        end
        idx = 0; held = 0; guard = 0; stall_left = stall;
        while (idx < path.size()) begin
            st = path[idx];
            if ((st == 3 || st == 5) && stall_left > 0) begin rdy = 1'b0; stall_left--; end
            else if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
            else rdy = 1'b1;
            MemReady = rdy;
            ALUFlags = fix_af ? af : 4'($urandom);
            @(negedge clk);
            check_outputs(st, ins, rdy);
            @(posedge clk);
            #1;
            if ((st == 6 || st == 7) && ins[20]) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA) m_flags[1:0] = ALUFlags[1:0];
            end
            if (st == 10) begin
                held++;
                if (held >= 10) break;
            end else if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
            guard++;
            if (guard > 300) begin
                n_cmp++; n_fail++;
                $error("FAIL timeout_%05h observed=%0d expected=<300", ins, guard);
                break;
            end
        end
    endtask

    // Asserts reset mid-cycle and checks the asynchronous return to FETCH with strobes held off
    task automatic reset_check(input string tag);
        reset = 1'b1;
        MemReady = 1'b1;
        #1;
        chk({tag, "_state"}, State, 0);
        chk({tag, "_undef"}, Undef, 0);
        chk({tag, "_flags"}, Flags, 0);
        @(negedge clk);
        chk({tag, "_strobes"}, {PCWrite, MemWrite, RegWrite, IRWrite}, 0);
        chk({tag, "_fetchsel"}, {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 7'b0_01_10_10);
        @(posedge clk);
        #1;
        chk({tag, "_state_held"}, State, 0);
        reset = 1'b0;
        m_flags = 4'b0000;
    endtask

    initial begin
        logic [31:12] ri;
        reset = 1'b1; Instr = '0; ALUFlags = 4'b0000; MemReady = 1'b1; m_flags = 4'b0000;
        @(posedge clk);
        #1;
        reset_check("por");

        run_instr(20'hE0811, 0, 0, 0, 4'b0000);
        run_instr(20'hE0521, 0, 0, 1, 4'b0100);
        chk("subs_flags", Flags, 4'b0100);
        run_instr(20'h0A000, 0, 0, 0, 4'b0000);
        run_instr(20'h1A000, 0, 0, 0, 4'b0000);
        run_instr(20'hE5912, 0, 3, 0, 4'b0000);
        run_instr(20'hE5812, 0, 2, 0, 4'b0000);
        run_instr(20'hE081F, 0, 0, 0, 4'b0000);
        run_instr(20'hE0331, 0, 0, 1, 4'b1011);
        chk("eors_flags_cv_kept", Flags, 4'b1000);

        for (int k = 0; k < 60; k++) begin
            ri = 20'($urandom);
            ri[31:28] = 4'($urandom_range(0, 14));
            ri[27:26] = 2'($urandom_range(0, 2));
            if (ri[27:26] == 2'b00) ri[24:21] = cmds[$urandom_range(0, 5)];
            run_instr(ri, 1, 0, 0, 4'b0000);
        end

        Instr = 20'hE5812;
        MemReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        MemReady = 1'b0;
        @(negedge clk);
        chk("midwr_state", State, 5);
        chk("midwr_memwrite", MemWrite, 1);
        #2;
        reset_check("midwr_rst");

        run_instr(20'hEC000, 0, 0, 0, 4'b0000);
        reset_check("undef_op11");
        run_instr(20'hF0811, 1, 0, 0, 4'b0000);
        reset_check("undef_cond15");
        run_instr(20'hE0611, 1, 0, 0, 4'b0000);
        reset_check("undef_cmd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT, default 1; 1 means memory states wait on MemReady, 0 means MemReady is ignored and treated as 1.
REQ-002 The block SHALL have parameter ALUCTL_W, default 3; it is the ALUControl width, and values >=3 enable EOR.
REQ-003 The block SHALL have one clock, clk, and its reset, reset, SHALL be asynchronous and active-high.
REQ-004 Ports SHALL be as follows.
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- Instr  in  [31:12]  current instruction word (held by datapath IR).
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- MemReady  in  1  memory completes access this cycle.
- PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath enables/selects.
- RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath selects.
- ALUControl  out  ALUCTL_W  ALU operation.
- Flags  out  4  architectural NZCV register.
- Undef  out  1  controller halted on an illegal instruction.
- State  out  4  current state encoding (debug).

Function
REQ-005 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNDEF=10.
REQ-006 Transitions SHALL be as follows.
- FETCH->DECODE on ready.
- DECODE dispatches by Op:
  - Op=00 with I=0 -> EXECR; Op=00 with I=1 -> EXECI.
  - Op=01 -> MEMADR.
  - Op=10 -> BRANCH.
  - Op=11, Cond=1111, or unsupported cmd -> UNDEF.
  - Failed condition -> FETCH.
- MEMADR -> MEMRD if L=1, else MEMWR.
- MEMRD -> MEMWB on ready.
- MEMWR -> FETCH on ready.
- EXECR/EXECI -> ALUWB, or -> FETCH for CMP.
- MEMWB, ALUWB and BRANCH -> FETCH.
- UNDEF is held until reset.
REQ-007 "Ready" SHALL mean MemReady=1 (or MEM_WAIT=0); FETCH, MEMRD and MEMWR SHALL hold state while not ready.
REQ-008 Per-state outputs SHALL be as follows; every unlisted output is 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=ready, PCWrite=ready.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWR: AdrSrc=1, MemWrite=1 for every cycle of the state.
- EXECR: ALU-decoded.
- EXECI: ALUSrcB=01, ALU-decoded.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1.
REQ-009 ImmSrc SHALL equal Op in all states.
REQ-010 RegSrc SHALL be: [0]=1 for a branch; [1]=1 for a store.
REQ-011 In MEMWB and ALUWB with Rd=15, PCWrite SHALL also be 1 and RegWrite SHALL stay 1.
REQ-012 The ALU decode of cmd=Funct[4:1] SHALL be: ADD 0100->0, SUB 0010->1, AND 0000->2, ORR 1100->3, CMP 1010->1 (no writeback), EOR 0001->4.
- EOR is decoded only when ALUCTL_W>=3; otherwise it goes to UNDEF.
- Outside EXECR/EXECI, ALUControl SHALL be 0 (ADD).
REQ-013 Condition evaluation SHALL use the standard ARM table (EQ..AL) on Flags; it is evaluated in DECODE only.
REQ-014 Flags update SHALL occur at the clock edge leaving EXECR/EXECI, only when S=1.
- NZ is loaded from ALUFlags[3:2] always.
- CV is loaded from ALUFlags[1:0] only for ADD, SUB or CMP.
REQ-015 Flags SHALL change at no other time.
REQ-016 Undef SHALL be 1 exactly while in UNDEF; in UNDEF, PCWrite, RegWrite, MemWrite and IRWrite SHALL be 0.
REQ-017 No instruction SHALL assert MemWrite or RegWrite when its condition fails.

Reset
REQ-018 Reset SHALL force, asynchronously, State=FETCH, Flags=0000 and Undef=0.
REQ-019 While reset is asserted, outputs SHALL carry the FETCH values with IRWrite=PCWrite=0.
REQ-020 Reset asserted in any state, including a mid-wait or UNDEF, SHALL abort the operation with no write strobe on the following edge.

Verification
REQ-021 The bench SHALL cover the following scenarios.
- ADD, Instr=20'hE0811, MemReady=1: states 0,1,6,8,0; ALUControl=0 in EXECR; RegWrite=1 only in ALUWB.
- SUBS, Instr=20'hE0521, ALUFlags=0100: Flags=0100 after EXECR. Then BEQ 20'h0A000 -> BRANCH with PCWrite=1.
- BNE, 20'h1A000, with Z=1: DECODE->FETCH; no BRANCH state; no PCWrite outside FETCH.
- LDR, 20'hE5912, with MemReady=0 for 3 cycles in MEMRD: State=3 held for 3 cycles, then MEMWB with RegWrite=1. STR 20'hE5812 shows MemWrite=1 held until ready.
- ADD to R15, 20'hE081F: ALUWB shows RegWrite=1 and PCWrite=1.
- Op=11, 20'hEC000: UNDEF with Undef=1 and no strobes for 10 cycles. Then reset -> State=0, Undef=0, Flags=0.
